// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register responder.
package i2c_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CTR_W = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_BYTE,
    DATA_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Single-cycle register-file port between the I2C target and its register bank.
interface i2c_target_regs_if;
  import i2c_pkg::*;

  logic [DATA_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser plus majority-free glitch filter for one I2C pad line.
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_f,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_LEN-1:0]    hist_q;

  // Synchroniser chain followed by a history of the last FILT_LEN samples; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, line_i});
      hist_q <= FILT_LEN'({hist_q, sync_q[SYNC_STAGES-1]});
    end
  end

  // Accept a new level only once the whole history agrees; emit one-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_f <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if ((&hist_q) && !line_f) begin
        line_f <= 1'b1;
        rise   <= 1'b1;
      end else if (!(|hist_q) && line_f) begin
        line_f <= 1'b0;
        fall   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing 8-bit register pointer and single-cycle register port.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      sda_t,
  output logic                      busy,
  i2c_target_regs_if.master         regs
);

  localparam logic [BIT_CTR_W-1:0] BITS_PER_BYTE = BIT_CTR_W'(8);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_tgt_state_t        state_q, state_d;
  logic [BIT_CTR_W-1:0]  bit_ctr_q, bit_ctr_d, bit_inc;
  logic [DATA_W-1:0]     shreg_q, shreg_d, shift_in;
  logic [DATA_W-1:0]     rd_sh_q, rd_sh_d;
  logic                  rnw_q, rnw_d;
  logic                  re_dly_q, re_dly_d;
  logic                  sda_t_q, sda_t_d;
  logic                  busy_q, busy_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .line_i(scl_i), .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .line_i(sda_i), .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign shift_in  = {shreg_q[DATA_W-2:0], sda_f};
  assign bit_inc   = bit_ctr_q + BIT_CTR_W'(1);

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_ctr_q <= '0;
      shreg_q   <= '0;
      rd_sh_q   <= '0;
      rnw_q     <= 1'b0;
      re_dly_q  <= 1'b0;
      sda_t_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_ctr_q <= bit_ctr_d;
      shreg_q   <= shreg_d;
      rd_sh_q   <= rd_sh_d;
      rnw_q     <= rnw_d;
      re_dly_q  <= re_dly_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end

  // Next-state and output decode; bus conditions override bit events.
  always_comb begin
    state_d   = state_q;
    bit_ctr_d = bit_ctr_q;
    shreg_d   = shreg_q;
    rnw_d     = rnw_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    re_dly_d  = re_q;
    rd_sh_d   = re_dly_q ? regs.reg_rdata : rd_sh_q;

    // Pointer advances the cycle after a write strobe.
    if (we_q) addr_d = addr_q + DATA_W'(1);

    if (stop_det) begin
      state_d = IDLE;
      sda_t_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_ctr_d = '0;
      sda_t_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR, PTR, WR_BYTE: begin
          if (scl_rise && bit_ctr_q != BITS_PER_BYTE) begin
            shreg_d   = shift_in;
            bit_ctr_d = bit_inc;
          end else if (scl_fall && bit_ctr_q == BITS_PER_BYTE) begin
            bit_ctr_d = '0;
            if (state_q == ADDR) begin
              if (shreg_q[DATA_W-1:1] == DEV_ADDR) begin
                sda_t_d = 1'b1;
                busy_d  = 1'b1;
                rnw_d   = shreg_q[0];
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end else if (state_q == PTR) begin
              addr_d  = shreg_q;
              sda_t_d = 1'b1;
              state_d = DATA_ACK;
            end else begin
              wdata_d = shreg_q;
              we_d    = 1'b1;
              sda_t_d = 1'b1;
              state_d = DATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && rnw_q) re_d = 1'b1;
          if (scl_fall) begin
            if (rnw_q) begin
              sda_t_d   = ~rd_sh_q[DATA_W-1];
              bit_ctr_d = BIT_CTR_W'(1);
              state_d   = RD_BYTE;
            end else begin
              sda_t_d   = 1'b0;
              bit_ctr_d = '0;
              state_d   = PTR;
            end
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_t_d   = 1'b0;
            bit_ctr_d = '0;
            state_d   = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_ctr_q == BITS_PER_BYTE) begin
              sda_t_d = 1'b0;
              state_d = RD_ACK;
            end else begin
              sda_t_d   = ~rd_sh_q[3'(BIT_CTR_W'(7) - bit_ctr_q)];
              bit_ctr_d = bit_inc;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            addr_d = addr_q + DATA_W'(1);
            if (sda_f == I2C_ACK) begin
              re_d      = 1'b1;
              bit_ctr_d = '0;
              state_d   = RD_BYTE;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_o           = 1'b0;
  assign sda_t           = sda_t_q;
  assign busy            = busy_q;
  assign regs.reg_addr   = addr_q;
  assign regs.reg_wdata  = wdata_q;
  assign regs.reg_we     = we_q;
  assign regs.reg_re     = re_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: drives I2C as a controller and checks target responses and register port.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus, sda_o, sda_t, busy;

  int checks = 0;
  int errors = 0;

  i2c_target_regs_if rif ();

  assign sda_bus = sda_m & ~sda_t;

  i2c_target_regs #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_t(sda_t), .busy(busy), .regs(rif)
  );

  always #5 clk = ~clk;

  // Register file model: regfile[i] = i ^ 0xFF, registered read.
  always @(posedge clk) if (rif.reg_re) rif.reg_rdata <= rif.reg_addr ^ 8'hFF;

  // Activity monitors.
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int re_cnt = 0, drv_cyc = 0, busy_cyc = 0, viol = 0;
  logic sda_t_prev = 1'b0;
  always @(posedge clk) begin
    if (rif.reg_we) begin
      wr_addr_q.push_back(rif.reg_addr);
      wr_data_q.push_back(rif.reg_wdata);
    end
    if (rif.reg_re) re_cnt <= re_cnt + 1;
    if (sda_t) drv_cyc <= drv_cyc + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (!rst && sda_t !== sda_t_prev && scl_m) viol <= viol + 1;
    sda_t_prev <= sda_t;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    b = sda_bus;  wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit);
  endtask

  task automatic test_reset();
    wait_clks(3);
    rst = 1'b0;
    wait_clks(10);
    checks++; if (sda_t !== 1'b0)         begin errors++; $display("FAIL reset_sda_t got %0b exp 0", sda_t); end
    checks++; if (sda_o !== 1'b0)         begin errors++; $display("FAIL reset_sda_o got %0b exp 0", sda_o); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (rif.reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got %h exp 00", rif.reg_addr); end
    checks++; if (rif.reg_wdata !== 8'h00 || rif.reg_we !== 1'b0 || rif.reg_re !== 1'b0)
      begin errors++; $display("FAIL reset_regport got wd=%h we=%b re=%b exp 00/0/0", rif.reg_wdata, rif.reg_we, rif.reg_re); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int n0 = wr_addr_q.size();
    bus_start();
    send_byte(8'h78, a0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %0b exp 1", busy); end
    send_byte(8'h10, a1);
    send_byte(8'hA5, a2);
    send_byte(8'h5A, a3);
    bus_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wr_acks got %b exp 0000", {a0, a1, a2, a3}); end
    checks++; if (wr_addr_q.size() - n0 !== 2) begin errors++; $display("FAIL wr_count got %0d exp 2", wr_addr_q.size() - n0); end
    else begin
      checks++; if (wr_addr_q[n0] !== 8'h10 || wr_data_q[n0] !== 8'hA5)
        begin errors++; $display("FAIL wr_first got %h=%h exp 10=a5", wr_addr_q[n0], wr_data_q[n0]); end
      checks++; if (wr_addr_q[n0+1] !== 8'h11 || wr_data_q[n0+1] !== 8'h5A)
        begin errors++; $display("FAIL wr_second got %h=%h exp 11=5a", wr_addr_q[n0+1], wr_data_q[n0+1]); end
    end
    checks++; if (rif.reg_addr !== 8'h12) begin errors++; $display("FAIL wr_final_addr got %h exp 12", rif.reg_addr); end
    checks++; if (busy !== 1'b0 || sda_t !== 1'b0) begin errors++; $display("FAIL wr_after_stop got busy=%b sda_t=%b exp 0/0", busy, sda_t); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int r0 = re_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h20, a1);
    bus_start();
    send_byte(8'h79, a2);
    recv_byte(d0, I2C_ACK);
    recv_byte(d1, I2C_NACK);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks got %b exp 000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'hDF) begin errors++; $display("FAIL rd_byte0 got %h exp df", d0); end
    checks++; if (d1 !== 8'hDE) begin errors++; $display("FAIL rd_byte1 got %h exp de", d1); end
    checks++; if (rif.reg_addr !== 8'h22) begin errors++; $display("FAIL rd_final_addr got %h exp 22", rif.reg_addr); end
    checks++; if (re_cnt - r0 !== 2) begin errors++; $display("FAIL rd_re_count got %0d exp 2", re_cnt - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got %0b exp 0", busy); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int w0 = wr_addr_q.size(), r0 = re_cnt, d0 = drv_cyc, b0 = busy_cyc;
    bus_start();
    send_byte(8'h7A, a0);
    send_byte(8'h55, a1);
    bus_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mm_acks got %b exp 11", {a0, a1}); end
    checks++; if (drv_cyc != d0) begin errors++; $display("FAIL mm_sda_driven got %0d cycles exp 0", drv_cyc - d0); end
    checks++; if (wr_addr_q.size() != w0 || re_cnt != r0)
      begin errors++; $display("FAIL mm_strobes got we=%0d re=%0d exp 0/0", wr_addr_q.size() - w0, re_cnt - r0); end
    checks++; if (busy_cyc != b0) begin errors++; $display("FAIL mm_busy got %0d cycles exp 0", busy_cyc - b0); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int n0 = wr_addr_q.size();
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h01, a2);
    send_byte(8'h02, a3);
    bus_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks got %b exp 0000", {a0, a1, a2, a3}); end
    checks++; if (wr_addr_q.size() - n0 !== 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", wr_addr_q.size() - n0); end
    else begin
      checks++; if (wr_addr_q[n0] !== 8'hFF || wr_data_q[n0] !== 8'h01)
        begin errors++; $display("FAIL wrap_first got %h=%h exp ff=01", wr_addr_q[n0], wr_data_q[n0]); end
      checks++; if (wr_addr_q[n0+1] !== 8'h00 || wr_data_q[n0+1] !== 8'h02)
        begin errors++; $display("FAIL wrap_second got %h=%h exp 00=02", wr_addr_q[n0+1], wr_data_q[n0+1]); end
    end
    checks++; if (rif.reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_final_addr got %h exp 01", rif.reg_addr); end
  endtask

  task automatic test_truncate();
    logic a0, a1;
    int n0 = wr_addr_q.size();
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h30, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL trunc_acks got %b exp 00", {a0, a1}); end
    checks++; if (wr_addr_q.size() != n0) begin errors++; $display("FAIL trunc_we got %0d exp 0", wr_addr_q.size() - n0); end
    checks++; if (sda_t !== 1'b0 || dut.state_q !== IDLE)
      begin errors++; $display("FAIL trunc_idle got sda_t=%b state=%0d exp 0/%0d", sda_t, dut.state_q, IDLE); end
    checks++; if (rif.reg_addr !== 8'h30) begin errors++; $display("FAIL trunc_addr_kept got %h exp 30", rif.reg_addr); end
  endtask

  task automatic test_glitch();
    logic a0, a1, b;
    // Low glitch on idle bus must not look like START.
    sda_m = 1'b0; wait_clks(1); sda_m = 1'b1; wait_clks(2 * Q);
    checks++; if (dut.state_q !== IDLE || busy !== 1'b0)
      begin errors++; $display("FAIL glitch_start got state=%0d busy=%b exp %0d/0", dut.state_q, busy, IDLE); end
    // High glitch while SDA low during a pointer bit must not look like STOP.
    bus_start();
    send_byte(8'h78, a0);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(1);
    sda_m = 1'b0; wait_clks(Q - 1);
    scl_m = 1'b0; wait_clks(Q);
    for (int i = 6; i >= 0; i--) begin
      b = (i == 2 || i == 0);
      write_bit(b);
    end
    read_bit(a1);
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL glitch_acks got %b exp 00", {a0, a1}); end
    checks++; if (rif.reg_addr !== 8'h05 || busy !== 1'b1)
      begin errors++; $display("FAIL glitch_stop got addr=%h busy=%b exp 05/1", rif.reg_addr, busy); end
    bus_stop();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i inside {6, 5, 4, 3});
    while (sda_t !== 1'b1 && t < 40) begin wait_clks(1); t++; end
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL mid_ack_driven got %0b exp 1", sda_t); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sda_t !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_rst_release got sda_t=%b busy=%b exp 0/0", sda_t, busy); end
    checks++; if (rif.reg_addr !== 8'h00 || rif.reg_we !== 1'b0 || rif.reg_re !== 1'b0 || rif.reg_wdata !== 8'h00)
      begin errors++; $display("FAIL mid_rst_regport got addr=%h wd=%h we=%b re=%b exp 00/00/0/0", rif.reg_addr, rif.reg_wdata, rif.reg_we, rif.reg_re); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_rst_state got %0d exp %0d", dut.state_q, IDLE); end
    wait_clks(2);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(10);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_truncate();
    test_glitch();
    checks++; if (viol != 0) begin errors++; $display("FAIL sda_change_scl_high got %0d exp 0", viol); end
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
